lora_status_tx: RTL and testbench
=================================

Name: lora_status_tx

Overview:
- Serialises the Mobile unit's control state (bell, led, rgb, rgb_mode) into a 4-byte framed UART packet on lora_tx, sitting directly downstream of btn_ctrl and driving the LoRa module's RX pin.
- Sends a packet whenever the state changes, when must_tx rises, and periodically as a keep-alive.
- Emits a one-cycle tick per completed packet for led_tick_blink.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 9600, UART bit rate; bit period BIT_CYC = CLK_FREQ/BAUD cycles (integer divide).
- REFRESH_CYC, 50_000_000, idle cycles between keep-alive packets.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- bell  input  1  bell state from btn_ctrl (clk domain)
- led  input  1  led state from btn_ctrl
- rgb  input  1  rgb enable from btn_ctrl
- rgb_mode  input  3  rgb mode from btn_ctrl
- must_tx  input  1  asynchronous force-send switch; rising edge requests a packet
- lora_tx  output  1  UART serial out, idle high
- busy  output  1  high while a packet is being sent
- lora_tx_tick  output  1  one-cycle pulse on packet completion

Behaviour:
- Reset values: lora_tx=1, busy=0, lora_tx_tick=0. Reset also clears snapshot=8'h00, must_pending=0, refresh counter=0, state=IDLE.
- Reset asserted mid-packet: lora_tx returns to 1 immediately (asynchronous), and the partial packet is abandoned.
- status byte = {2'b00, rgb_mode, rgb, led, bell}.
- Packet bytes, in order: 8'hA5, status, ~status, 8'h5A.
- Each byte is sent as 8N1, LSB first: one start bit (0), 8 data bits, one stop bit (1), each held BIT_CYC cycles. Bytes are back-to-back with no inter-byte gap.
- must_tx: 2-flop synchroniser followed by a rising-edge detector. A detected edge sets must_pending in any state.
- Refresh counter: increments in IDLE and saturates at REFRESH_CYC-1. It is cleared on leaving IDLE.
- Trigger, evaluated in IDLE only: (current status != snapshot) OR must_pending OR (refresh counter == REFRESH_CYC-1).
- Simultaneous trigger sources produce exactly one packet.
- FSM states: IDLE, LOAD, START, DATA, STOP, DONE.
  - IDLE -> LOAD on trigger.
  - LOAD (1 cycle): latch status into snapshot and the tx buffer, clear must_pending, set byte_idx=0, set busy=1.
  - START: lora_tx=0 for BIT_CYC cycles -> DATA.
  - DATA: shift 8 bits, bit_idx 0..7, BIT_CYC cycles each -> STOP.
  - STOP: lora_tx=1 for BIT_CYC cycles. If byte_idx==3 go to DONE; otherwise increment byte_idx and go to START.
  - DONE (1 cycle): lora_tx_tick=1, busy=0 -> IDLE.
- Latency: if the trigger is true in IDLE at edge N, LOAD runs in cycle N+1 and lora_tx falls at edge N+2.
- Packet duration: 40*BIT_CYC cycles from the start-bit edge to the end of the last stop bit.
- Input changes during a packet are not queued separately. On return to IDLE the compare against snapshot re-triggers if needed, so the latest state is always sent.
- A must_tx edge during a packet causes exactly one follow-up packet.
- The bit timer is a down-counter from BIT_CYC-1 to 0. It must handle BIT_CYC >= 2 correctly.

Optional Feature:
- Macro: LORA_TX_PARITY_EN.
- Defined: frames are 8E1. An even parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit (extra state PARITY). Packet length becomes 44*BIT_CYC cycles.
- Undefined: 8N1 as above, and no parity logic is present.

Test Plan:
- CLK_FREQ=1000, BAUD=100 (BIT_CYC=10), REFRESH_CYC=5000. Reset, then hold inputs at 0 for 4000 cycles -> lora_tx stays 1, busy=0, no tick.
- bell=1 at cycle T -> lora_tx falls at T+2; decoded bytes A5 01 FE 5A; busy high for 402 cycles; one lora_tx_tick at the end.
- rgb_mode=3'b101, rgb=1, led=1 set in the same cycle -> exactly one packet with status 8'h2E: A5 2E D1 5A.
- must_tx raised mid-packet with inputs unchanged -> the current packet completes, then exactly one more identical packet; two ticks total.
- Inputs static after one packet -> the next identical packet starts 5000 cycles after DONE (keep-alive); no other traffic.
- rst pulsed during the DATA state of byte 2 -> lora_tx=1 immediately and busy=0. After release, the nonzero status re-triggers a full packet from the A5 header.
- With LORA_TX_PARITY_EN and status 8'h01 -> the parity bits after each byte are 0,1,1,0; the packet lasts 440 cycles.

Source files
------------

// File: rtl/lora_status_tx.sv
// lora_status_tx: frames the Mobile unit control state (bell, led, rgb, rgb_mode)
// into a 4-byte UART packet {A5, status, ~status, 5A} on lora_tx. A packet is sent
// on a status change, on a must_tx rising edge, or as a periodic keep-alive.
// Build option: define LORA_TX_PARITY_EN for 8E1 frames (default 8N1).
module lora_status_tx #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned REFRESH_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bell,
  input  logic       led,
  input  logic       rgb,
  input  logic [2:0] rgb_mode,
  input  logic       must_tx,
  output logic       lora_tx,
  output logic       busy,
  output logic       lora_tx_tick
);

  localparam int unsigned BIT_CYC   = CLK_FREQ / BAUD;
  localparam int unsigned TIMER_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int unsigned REFRESH_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  localparam logic [TIMER_W-1:0]   BIT_LAST     = TIMER_W'(BIT_CYC - 1);
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_CYC - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
`ifdef LORA_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd6;
`endif

  logic [2:0]           state_q, state_d;
  logic [7:0]           snapshot_q, snapshot_d;
  logic [31:0]          frame_q, frame_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [REFRESH_W-1:0] refresh_q, refresh_d;
  logic                 must_pending_q, must_pending_d;
  logic                 lora_tx_d, busy_d, tick_d;

  logic [1:0] must_sync;
  logic       must_prev;
  logic       must_edge;
  logic [7:0] status;
  logic       trigger;

  assign status    = {2'b00, rgb_mode, rgb, led, bell};
  assign must_edge = must_sync[1] & ~must_prev;
  assign trigger   = (status != snapshot_q) | must_pending_q | (refresh_q == REFRESH_LAST);

  // Synchronise the asynchronous must_tx switch and keep its previous value for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      must_sync <= 2'b00;
      must_prev <= 1'b0;
    end else begin
      must_sync <= {must_sync[0], must_tx};
      must_prev <= must_sync[1];
    end
  end

  // State and datapath registers; serial outputs are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      snapshot_q     <= 8'h00;
      frame_q        <= 32'h0;
      byte_idx_q     <= 2'd0;
      bit_idx_q      <= 3'd0;
      timer_q        <= '0;
      refresh_q      <= '0;
      must_pending_q <= 1'b0;
      lora_tx        <= 1'b1;
      busy           <= 1'b0;
      lora_tx_tick   <= 1'b0;
    end else begin
      state_q        <= state_d;
      snapshot_q     <= snapshot_d;
      frame_q        <= frame_d;
      byte_idx_q     <= byte_idx_d;
      bit_idx_q      <= bit_idx_d;
      timer_q        <= timer_d;
      refresh_q      <= refresh_d;
      must_pending_q <= must_pending_d;
      lora_tx        <= lora_tx_d;
      busy           <= busy_d;
      lora_tx_tick   <= tick_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d        = state_q;
    snapshot_d     = snapshot_q;
    frame_d        = frame_q;
    byte_idx_d     = byte_idx_q;
    bit_idx_d      = bit_idx_q;
    timer_d        = timer_q;
    refresh_d      = refresh_q;
    must_pending_d = must_pending_q;
    lora_tx_d      = 1'b1;
    busy_d         = 1'b0;
    tick_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) state_d = LOAD;
      end
      LOAD: begin
        snapshot_d     = status;
        frame_d        = {8'h5A, ~status, status, 8'hA5};
        must_pending_d = 1'b0;
        byte_idx_d     = 2'd0;
        bit_idx_d      = 3'd0;
        timer_d        = BIT_LAST;
        state_d        = START;
      end
      START: begin
        if (timer_q == '0) begin
          timer_d   = BIT_LAST;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = BIT_LAST;
          if (bit_idx_q == 3'd7) begin
`ifdef LORA_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
`ifdef LORA_TX_PARITY_EN
      PARITY: begin
        if (timer_q == '0) begin
          timer_d = BIT_LAST;
          state_d = STOP;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
`endif
      STOP: begin
        if (timer_q == '0) begin
          timer_d = BIT_LAST;
          if (byte_idx_q == 2'd3) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A must_tx edge is remembered in every state, including the LOAD that clears it
    if (must_edge) must_pending_d = 1'b1;

    // Keep-alive counter runs only while idle and saturates at its terminal count
    if (state_q == IDLE) begin
      if (refresh_q != REFRESH_LAST) refresh_d = refresh_q + REFRESH_W'(1);
    end else begin
      refresh_d = '0;
    end

    busy_d = (state_d != IDLE);
    tick_d = (state_d == DONE);
    case (state_d)
      START:   lora_tx_d = 1'b0;
      DATA:    lora_tx_d = frame_d[{byte_idx_d, bit_idx_d}];
`ifdef LORA_TX_PARITY_EN
      PARITY:  lora_tx_d = ^frame_d[{byte_idx_d, 3'b000} +: 8];
`endif
      default: lora_tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_lora_status_tx.sv
// Directed bench for lora_status_tx at BIT_CYC=10, REFRESH_CYC=5000.
module tb_lora_status_tx;

  localparam int BIT = 10;
`ifdef LORA_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int PKT = 4 * FRAME * BIT;

  logic       clk;
  logic       rst;
  logic       bell;
  logic       led;
  logic       rgb;
  logic [2:0] rgb_mode;
  logic       must_tx;
  logic       lora_tx;
  logic       busy;
  logic       lora_tx_tick;

  int checks = 0;
  int passed = 0;
  int tick_cnt = 0;
  int busy_cnt = 0;
  int low_cnt = 0;

  lora_status_tx #(.CLK_FREQ(1000), .BAUD(100), .REFRESH_CYC(5000)) dut (
    .clk(clk), .rst(rst), .bell(bell), .led(led), .rgb(rgb), .rgb_mode(rgb_mode),
    .must_tx(must_tx), .lora_tx(lora_tx), .busy(busy), .lora_tx_tick(lora_tx_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activity counters sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (lora_tx_tick === 1'b1) tick_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (lora_tx === 1'b0) low_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_low(input int limit, output int n);
    n = 0;
    while (lora_tx !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    while (lora_tx_tick !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at the first sampled cycle of the first start bit; samples mid-bit
  task automatic rx_from_start(output logic [31:0] bytes, output logic [3:0] par,
                               output logic fok);
    logic [FRAME-1:0] bits;
    bytes = '0;
    par   = '0;
    fok   = 1'b1;
    bits  = '0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < FRAME; j++) begin
        if (b == 0 && j == 0) repeat (BIT / 2) @(negedge clk);
        else repeat (BIT) @(negedge clk);
        bits[j] = lora_tx;
      end
      if (bits[0] !== 1'b0 || bits[FRAME-1] !== 1'b1) fok = 1'b0;
      bytes[b*8 +: 8] = bits[8:1];
`ifdef LORA_TX_PARITY_EN
      par[b] = bits[9];
`endif
    end
  endtask

  initial begin
    logic [31:0] bytes;
    logic [3:0]  par;
    logic        fok;
    int          n;
    int          k0;
    int          b0;
    int          l0;

    rst = 1'b1; bell = 1'b0; led = 1'b0; rgb = 1'b0; rgb_mode = 3'b000; must_tx = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lora_tx", 32'(lora_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(lora_tx_tick), 32'd0);
    rst = 1'b0;

    // Quiet inputs: no traffic
    k0 = tick_cnt; b0 = busy_cnt; l0 = low_cnt;
    repeat (4000) @(negedge clk);
    chk("idle_low", 32'(low_cnt - l0), 32'd0);
    chk("idle_busy", 32'(busy_cnt - b0), 32'd0);
    chk("idle_tick", 32'(tick_cnt - k0), 32'd0);

    // bell=1: latency, bytes, busy length, one tick
    k0 = tick_cnt; b0 = busy_cnt;
    bell = 1'b1;
    @(negedge clk);
    chk("lat_busy_load", 32'(busy), 32'd1);
    chk("lat_tx_load", 32'(lora_tx), 32'd1);
    @(negedge clk);
    chk("lat_tx_start", 32'(lora_tx), 32'd0);
    rx_from_start(bytes, par, fok);
    chk("p1_bytes", bytes, 32'h5AFE01A5);
    chk("p1_framing", 32'(fok), 32'd1);
`ifdef LORA_TX_PARITY_EN
    chk("p1_parity", 32'(par), 32'h6);
`endif
    repeat (20) @(negedge clk);
    chk("p1_busy_len", 32'(busy_cnt - b0), 32'(PKT + 2));
    chk("p1_ticks", 32'(tick_cnt - k0), 32'd1);

    // Several inputs changed together: one packet with status 2E
    k0 = tick_cnt;
    rgb_mode = 3'b101; rgb = 1'b1; led = 1'b1; bell = 1'b0;
    wait_low(20, n);
    chk("p2_start", 32'(lora_tx), 32'd0);
    rx_from_start(bytes, par, fok);
    chk("p2_bytes", bytes, 32'h5AD12EA5);
    chk("p2_framing", 32'(fok), 32'd1);
    repeat (60) @(negedge clk);
    chk("p2_ticks", 32'(tick_cnt - k0), 32'd1);
    chk("p2_idle_busy", 32'(busy), 32'd0);
    chk("p2_idle_tx", 32'(lora_tx), 32'd1);

    // must_tx raised mid-packet: exactly one identical follow-up packet
    k0 = tick_cnt;
    bell = 1'b1;
    wait_low(20, n);
    chk("p3_start", 32'(lora_tx), 32'd0);
    repeat (100) @(negedge clk);
    must_tx = 1'b1;
    wait_tick(PKT, n);
    chk("p3_tick", 32'(lora_tx_tick), 32'd1);
    wait_low(30, n);
    chk("p4_start", 32'(lora_tx), 32'd0);
    rx_from_start(bytes, par, fok);
    chk("p4_bytes", bytes, 32'h5AD02FA5);
    wait_tick(40, n);
    chk("p4_tick", 32'(lora_tx_tick), 32'd1);

    // Static inputs: keep-alive after 5000 idle cycles
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lora_tx !== 1'b0 && n < 6000);
    chk("keepalive_gap", 32'(n), 32'd5002);
    chk("must_ticks", 32'(tick_cnt - k0), 32'd2);
    rx_from_start(bytes, par, fok);
    chk("ka_bytes", bytes, 32'h5AD02FA5);
    wait_tick(40, n);
    chk("ka_tick", 32'(lora_tx_tick), 32'd1);

    // Reset inside byte 2 data, then full resend of the current status
    must_tx = 1'b0;
    bell = 1'b0;
    wait_low(20, n);
    chk("p5_start", 32'(lora_tx), 32'd0);
    repeat (250) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_tx", 32'(lora_tx), 32'd1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    k0 = tick_cnt;
    wait_low(20, n);
    chk("p6_start", 32'(lora_tx), 32'd0);
    rx_from_start(bytes, par, fok);
    chk("p6_bytes", bytes, 32'h5AD12EA5);
    repeat (30) @(negedge clk);
    chk("p6_ticks", 32'(tick_cnt - k0), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
